// File: rtl/mkio_pkg.sv
// Shared types and constants for the MKIO dual-redundant line front-end.
`timescale 1ns/1ps
package mkio_pkg;

    localparam int DEFAULT_FILT_LEN = 3;
    localparam int DEFAULT_IDLE_CYC = 96;
    localparam int DEFAULT_HOLD_CYC = 8;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RX_A    = 3'd1;
    localparam state_t ST_RX_B    = 3'd2;
    localparam state_t ST_TX      = 3'd3;
    localparam state_t ST_TX_HOLD = 3'd4;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_t;

    localparam logic [1:0] ACT_NONE = 2'b00;
    localparam logic [1:0] ACT_A    = 2'b01;
    localparam logic [1:0] ACT_B    = 2'b10;

    typedef struct packed {
        logic l1;
        logic l0;
    } line_pair_t;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mkio_glitch_filter.sv
// One receive line: two-flop synchroniser followed by a run-length stability filter.
`timescale 1ns/1ps
module mkio_glitch_filter
    import mkio_pkg::*;
#(
    parameter int FILT_LEN = DEFAULT_FILT_LEN
) (
    input  logic clk32,
    input  logic reset,
    input  logic line,
    output logic filt
);

    localparam int CW = cnt_width(FILT_LEN);
    localparam logic [CW-1:0] RUN_MAX = CW'(FILT_LEN - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= line;
            sync2 <= sync1;
        end
    end

    // run_cnt counts consecutive samples disagreeing with filt; the FILT_LEN-th flips it.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            filt    <= 1'b0;
            run_cnt <= '0;
        end else if (sync2 == filt) begin
            run_cnt <= '0;
        end else if (run_cnt == RUN_MAX) begin
            filt    <= sync2;
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mkio_bus_select.sv
// A/B channel lock, transmit steering and receiver blanking for the MKIO line front-end.
`timescale 1ns/1ps
module mkio_bus_select
    import mkio_pkg::*;
#(
    parameter int FILT_LEN = DEFAULT_FILT_LEN,
    parameter int IDLE_CYC = DEFAULT_IDLE_CYC,
    parameter int HOLD_CYC = DEFAULT_HOLD_CYC
) (
    input  logic       clk32,
    input  logic       reset,
    input  logic       DI1A,
    input  logic       DI0A,
    input  logic       DI1B,
    input  logic       DI0B,
    input  logic       tx_busy,
    input  logic       DO1_tx,
    input  logic       DO0_tx,
    output logic       DI1,
    output logic       DI0,
    output logic       DO1A,
    output logic       DO0A,
    output logic       DO1B,
    output logic       DO0B,
    output logic       TX_INHIBIT_A,
    output logic       TX_INHIBIT_B,
    output logic       RX_STROB_A,
    output logic       RX_STROB_B,
    output logic [1:0] active_ch,
    output logic       collision
);

    localparam int IW = cnt_width(IDLE_CYC);
    localparam int HW = cnt_width(HOLD_CYC);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYC - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC - 1);

    line_pair_t    filt_a;
    line_pair_t    filt_b;
    logic          act_a;
    logic          act_b;
    logic          act_a_prev;
    logic          act_b_prev;
    logic          act_locked;

    state_t        state;
    state_t        next_state;
    ch_t           last_ch;
    logic          coll_armed;
    logic          coll_set;
    logic [IW-1:0] idle_cnt;
    logic [HW-1:0] hold_cnt;

    line_pair_t    tx_line;
    line_pair_t    di_d;
    line_pair_t    do_a_d;
    line_pair_t    do_b_d;
    logic [1:0]    active_d;
    logic          inh_a_d;
    logic          inh_b_d;
    logic          strob_a_d;
    logic          strob_b_d;

    mkio_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_1a (
        .clk32 (clk32),
        .reset (reset),
        .line  (DI1A),
        .filt  (filt_a.l1)
    );

    mkio_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_0a (
        .clk32 (clk32),
        .reset (reset),
        .line  (DI0A),
        .filt  (filt_a.l0)
    );

    mkio_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_1b (
        .clk32 (clk32),
        .reset (reset),
        .line  (DI1B),
        .filt  (filt_b.l1)
    );

    mkio_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_0b (
        .clk32 (clk32),
        .reset (reset),
        .line  (DI0B),
        .filt  (filt_b.l0)
    );

    // Both lines high at once is a line fault but still counts as a busy bus.
    assign act_a      = filt_a.l1 | filt_a.l0;
    assign act_b      = filt_b.l1 | filt_b.l0;
    assign act_locked = (state == ST_RX_B) ? act_b : act_a;
    assign tx_line    = {DO1_tx, DO0_tx};

    always_comb begin
        next_state = state;
        coll_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_busy) begin
                    next_state = ST_TX;
                end else if (act_a) begin
                    next_state = ST_RX_A;
                    coll_set   = act_b;
                end else if (act_b) begin
                    next_state = ST_RX_B;
                end
            end
            ST_RX_A: begin
                if (tx_busy) begin
                    next_state = ST_TX;
                end else if (idle_cnt == IDLE_MAX) begin
                    next_state = ST_IDLE;
                end
                coll_set = coll_armed & act_b & ~act_b_prev;
            end
            ST_RX_B: begin
                if (tx_busy) begin
                    next_state = ST_TX;
                end else if (idle_cnt == IDLE_MAX) begin
                    next_state = ST_IDLE;
                end
                coll_set = coll_armed & act_a & ~act_a_prev;
            end
            ST_TX: begin
                if (!tx_busy) begin
                    next_state = ST_TX_HOLD;
                end
            end
            ST_TX_HOLD: begin
                if (tx_busy) begin
                    next_state = ST_TX;
                end else if (hold_cnt == HOLD_MAX) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_ch    <= CH_A;
            coll_armed <= 1'b1;
            act_a_prev <= 1'b0;
            act_b_prev <= 1'b0;
        end else begin
            state      <= next_state;
            act_a_prev <= act_a;
            act_b_prev <= act_b;
            if (next_state == ST_RX_A) begin
                last_ch <= CH_A;
            end else if (next_state == ST_RX_B) begin
                last_ch <= CH_B;
            end
            // One collision report per lock; re-armed only once the bus is idle again.
            if (coll_set) begin
                coll_armed <= 1'b0;
            end else if (state == ST_IDLE) begin
                coll_armed <= 1'b1;
            end
        end
    end

    // idle_cnt saturates at its terminal value so a stalled exit can never wrap it.
    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            if ((state == ST_RX_A || state == ST_RX_B) && next_state == state) begin
                if (act_locked) begin
                    idle_cnt <= '0;
                end else if (idle_cnt != IDLE_MAX) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
            if (state == ST_TX_HOLD && next_state == ST_TX_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    // Outputs are decoded from next_state so each register lands together with its state.
    always_comb begin
        di_d      = '0;
        do_a_d    = '0;
        do_b_d    = '0;
        active_d  = ACT_NONE;
        inh_a_d   = 1'b1;
        inh_b_d   = 1'b1;
        strob_a_d = 1'b1;
        strob_b_d = 1'b1;
        case (next_state)
            ST_RX_A: begin
                di_d     = filt_a;
                active_d = ACT_A;
            end
            ST_RX_B: begin
                di_d     = filt_b;
                active_d = ACT_B;
            end
            ST_TX: begin
                if (last_ch == CH_A) begin
                    do_a_d    = tx_line;
                    inh_a_d   = 1'b0;
                    strob_a_d = 1'b0;
                end else begin
                    do_b_d    = tx_line;
                    inh_b_d   = 1'b0;
                    strob_b_d = 1'b0;
                end
            end
            ST_TX_HOLD: begin
                if (last_ch == CH_A) begin
                    strob_a_d = 1'b0;
                end else begin
                    strob_b_d = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            DI1          <= 1'b0;
            DI0          <= 1'b0;
            DO1A         <= 1'b0;
            DO0A         <= 1'b0;
            DO1B         <= 1'b0;
            DO0B         <= 1'b0;
            TX_INHIBIT_A <= 1'b1;
            TX_INHIBIT_B <= 1'b1;
            RX_STROB_A   <= 1'b1;
            RX_STROB_B   <= 1'b1;
            active_ch    <= ACT_NONE;
            collision    <= 1'b0;
        end else begin
            DI1          <= di_d.l1;
            DI0          <= di_d.l0;
            DO1A         <= do_a_d.l1;
            DO0A         <= do_a_d.l0;
            DO1B         <= do_b_d.l1;
            DO0B         <= do_b_d.l0;
            TX_INHIBIT_A <= inh_a_d;
            TX_INHIBIT_B <= inh_b_d;
            RX_STROB_A   <= strob_a_d;
            RX_STROB_B   <= strob_b_d;
            active_ch    <= active_d;
            collision    <= coll_set;
        end
    end

endmodule

// File: tb/tb_mkio_bus_select.sv
// Randomised self-checking bench for mkio_bus_select against a waveform-level reference model.
`timescale 1ns/1ps
module tb_mkio_bus_select;

    localparam int FL   = 3;
    localparam int IC   = 96;
    localparam int HC   = 8;
    localparam int LAT  = FL + 3;
    localparam int MAXN = 1200;
    localparam logic [12:0] RESET_VEC = 13'b00_0000_11_11_00_0;

    logic       clk32;
    logic       reset;
    logic       DI1A, DI0A, DI1B, DI0B;
    logic       tx_busy, DO1_tx, DO0_tx;
    logic       DI1, DI0;
    logic       DO1A, DO0A, DO1B, DO0B;
    logic       TX_INHIBIT_A, TX_INHIBIT_B, RX_STROB_A, RX_STROB_B;
    logic [1:0] active_ch;
    logic       collision;

    int checks = 0;
    int errors = 0;

    logic pa1 [MAXN];
    logic pa0 [MAXN];
    logic pb1 [MAXN];
    logic pb0 [MAXN];
    int   pat_len;

    mkio_bus_select #(.FILT_LEN(FL), .IDLE_CYC(IC), .HOLD_CYC(HC)) dut (
        .clk32        (clk32),
        .reset        (reset),
        .DI1A         (DI1A),
        .DI0A         (DI0A),
        .DI1B         (DI1B),
        .DI0B         (DI0B),
        .tx_busy      (tx_busy),
        .DO1_tx       (DO1_tx),
        .DO0_tx       (DO0_tx),
        .DI1          (DI1),
        .DI0          (DI0),
        .DO1A         (DO1A),
        .DO0A         (DO0A),
        .DO1B         (DO1B),
        .DO0B         (DO0B),
        .TX_INHIBIT_A (TX_INHIBIT_A),
        .TX_INHIBIT_B (TX_INHIBIT_B),
        .RX_STROB_A   (RX_STROB_A),
        .RX_STROB_B   (RX_STROB_B),
        .active_ch    (active_ch),
        .collision    (collision)
    );

    initial clk32 = 1'b0;
    always #16 clk32 = ~clk32;

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    function automatic logic [12:0] out_vec();
        return {DI1, DI0, DO1A, DO0A, DO1B, DO0B, TX_INHIBIT_A, TX_INHIBIT_B,
                RX_STROB_A, RX_STROB_B, active_ch, collision};
    endfunction

    task automatic clear_pattern();
        for (int i = 0; i < MAXN; i++) begin
            pa1[i] = 1'b0; pa0[i] = 1'b0; pb1[i] = 1'b0; pb0[i] = 1'b0;
        end
        pat_len = 0;
    endtask

    // Manchester word: each 1 us bit is 16 cycles of the bit value on line 1, then 16 inverted.
    task automatic put_word(input logic on_b, input int start, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            for (int k = 0; k < 32; k++) begin
                logic hi;
                int   idx;
                hi  = (k < 16) ? v : ~v;
                idx = start + b * 32 + k;
                if (on_b) begin pb1[idx] = hi; pb0[idx] = ~hi; end
                else      begin pa1[idx] = hi; pa0[idx] = ~hi; end
            end
        end
        if (start + nbits * 32 > pat_len) pat_len = start + nbits * 32;
    endtask

    task automatic put_pulse(input logic on_b, input logic line1, input int start, input int len);
        for (int i = start; i < start + len; i++) begin
            if (on_b && line1)       pb1[i] = 1'b1;
            else if (on_b)           pb0[i] = 1'b1;
            else if (line1)          pa1[i] = 1'b1;
            else                     pa0[i] = 1'b1;
        end
        if (start + len > pat_len) pat_len = start + len;
    endtask

    // Plays the stored pin pattern from an idle bus. The earliest-active channel wins (A on a tie),
    // DI is that channel's pins LAT cycles late, the lock drops IDLE_CYC cycles after its last
    // filtered edge (one cycle ahead of DI's), and the other channel's first start gives one pulse.
    task automatic run_rx(input string name, input int cycles);
        int   sa, sb, ea, eb, sel_start, sel_end, oth_start, release_at, total;
        logic sel_b;
        sa = -1; sb = -1; ea = 0; eb = 0;
        for (int i = 0; i < pat_len; i++) begin
            if (pa1[i] | pa0[i]) begin if (sa < 0) sa = i; ea = i + 1; end
            if (pb1[i] | pb0[i]) begin if (sb < 0) sb = i; eb = i + 1; end
        end
        sel_b      = (sa < 0) || (sb >= 0 && sb < sa);
        sel_start  = sel_b ? sb : sa;
        sel_end    = sel_b ? eb : ea;
        oth_start  = sel_b ? sa : sb;
        release_at = sel_end + LAT - 1 + IC;
        total      = (cycles > 0) ? cycles : release_at + 10;
        tx_busy = 1'b0;
        for (int r = 0; r < total; r++) begin
            int         o;
            logic [1:0] exp_di;
            logic [1:0] exp_act;
            logic       exp_col;
            if (r < pat_len) begin
                DI1A = pa1[r]; DI0A = pa0[r]; DI1B = pb1[r]; DI0B = pb0[r];
            end else begin
                DI1A = 1'b0; DI0A = 1'b0; DI1B = 1'b0; DI0B = 1'b0;
            end
            tick();
            o = r + 1;
            exp_di = 2'b00;
            if (o - LAT >= 0 && o - LAT < pat_len && o < release_at)
                exp_di = sel_b ? {pb1[o-LAT], pb0[o-LAT]} : {pa1[o-LAT], pa0[o-LAT]};
            exp_act = (o >= sel_start + LAT && o < release_at) ? (sel_b ? 2'b10 : 2'b01) : 2'b00;
            exp_col = (oth_start >= 0) && (o == oth_start + LAT);
            checks++;
            if ({DI1, DI0} !== exp_di) begin
                errors++;
                $display("[TB] FAIL %s di cycle %0d: got %b want %b", name, o, {DI1, DI0}, exp_di);
            end
            checks++;
            if (active_ch !== exp_act) begin
                errors++;
                $display("[TB] FAIL %s active_ch cycle %0d: got %b want %b", name, o, active_ch, exp_act);
            end
            checks++;
            if (collision !== exp_col) begin
                errors++;
                $display("[TB] FAIL %s collision cycle %0d: got %b want %b", name, o, collision, exp_col);
            end
        end
    endtask

    // Transmit bursts toward one side. The selected side carries the previous cycle's DO_tx while
    // busy, is inhibited whenever not busy, and keeps its receiver blanked until HOLD_CYC cycles
    // after the inhibit returns. A short receive burst on A during the first burst must be ignored.
    task automatic run_tx(input string name, input logic on_b, input int bursts);
        logic busy_q[$];
        int   last_busy;
        for (int b = 0; b < bursts; b++) begin
            int hi, lo;
            hi = $urandom_range(20, 40);
            lo = (b == bursts - 1) ? HC + 6 : $urandom_range(1, HC - 1);
            repeat (hi) busy_q.push_back(1'b1);
            repeat (lo) busy_q.push_back(1'b0);
        end
        last_busy = -1000;
        for (int s = 0; s < busy_q.size(); s++) begin
            int         o;
            logic       d1, d0;
            logic [3:0] exp_sel, got_sel, got_oth;
            d1 = 1'($urandom_range(0, 1));
            d0 = 1'($urandom_range(0, 1));
            tx_busy = busy_q[s];
            DO1_tx  = d1;
            DO0_tx  = d0;
            DI1A    = (s >= 5 && s < 16);
            DI0A    = 1'b0;
            DI1B    = 1'b0;
            DI0B    = 1'b0;
            tick();
            o = s + 1;
            if (busy_q[s]) last_busy = s;
            exp_sel = {busy_q[s] ? {d1, d0} : 2'b00, ~busy_q[s], ~(o - last_busy <= HC + 1)};
            got_sel = on_b ? {DO1B, DO0B, TX_INHIBIT_B, RX_STROB_B} : {DO1A, DO0A, TX_INHIBIT_A, RX_STROB_A};
            got_oth = on_b ? {DO1A, DO0A, TX_INHIBIT_A, RX_STROB_A} : {DO1B, DO0B, TX_INHIBIT_B, RX_STROB_B};
            checks++;
            if (got_sel !== exp_sel) begin
                errors++;
                $display("[TB] FAIL %s tx side {do1,do0,inh,strob} cycle %0d: got %b want %b", name, o, got_sel, exp_sel);
            end
            checks++;
            if (got_oth !== 4'b0011) begin
                errors++;
                $display("[TB] FAIL %s idle side {do1,do0,inh,strob} cycle %0d: got %b want 0011", name, o, got_oth);
            end
            checks++;
            if ({DI1, DI0, active_ch, collision} !== 5'b0) begin
                errors++;
                $display("[TB] FAIL %s rx blanking cycle %0d: got %b want 00000", name, o, {DI1, DI0, active_ch, collision});
            end
        end
        tx_busy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) tick();
        checks++;
        if (out_vec() !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL reset held: got %b want %b", out_vec(), RESET_VEC);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (out_vec() !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL reset released: got %b want %b", out_vec(), RESET_VEC);
        end
    endtask

    task automatic test_glitch();
        for (int n = 0; n < 2; n++) begin
            int len;
            len = $urandom_range(1, FL - 1);
            if (n == 0) DI1A = 1'b1; else DI0B = 1'b1;
            repeat (len) tick();
            DI1A = 1'b0;
            DI0B = 1'b0;
            for (int i = 0; i < 15; i++) begin
                tick();
                checks++;
                if ({DI1, DI0, active_ch, collision} !== 5'b0) begin
                    errors++;
                    $display("[TB] FAIL glitch len %0d cycle %0d: got %b want 00000", len, i, {DI1, DI0, active_ch, collision});
                end
            end
        end
    endtask

    task automatic test_word_a();
        clear_pattern();
        put_word(1'b0, 0, $urandom_range(6, 14));
        run_rx("word_a", 0);
    endtask

    task automatic test_simultaneous();
        clear_pattern();
        put_word(1'b0, 0, 12);
        for (int i = 0; i < pat_len; i++) begin
            pb1[i] = pa0[i];
            pb0[i] = pa1[i];
        end
        run_rx("simultaneous", 0);
    endtask

    task automatic test_collision_late();
        int off;
        clear_pattern();
        off = $urandom_range(40, 200);
        put_word(1'b0, 0, 20);
        put_pulse(1'b1, 1'b1, off, 40);
        put_pulse(1'b1, 1'b0, off + 70, 40);
        run_rx("collision_late", 0);
    endtask

    task automatic test_b_first();
        clear_pattern();
        put_word(1'b1, 0, 16);
        put_word(1'b0, $urandom_range(1, 10), 8);
        run_rx("b_first", 0);
    endtask

    task automatic test_response_b();
        clear_pattern();
        put_word(1'b1, 0, 8);
        run_rx("response_rx_b", pat_len + LAT + 20);
        run_tx("response_tx_b", 1'b1, 3);
    endtask

    task automatic test_reset_mid_tx();
        logic d1;
        d1 = 1'b0;
        tx_busy = 1'b1;
        for (int s = 0; s < 12; s++) begin
            d1 = ~d1;
            DO1_tx = d1;
            DO0_tx = ~d1;
            tick();
        end
        checks++;
        if ({DO1B, DO0B, DO1A, DO0A} !== {d1, ~d1, 2'b00}) begin
            errors++;
            $display("[TB] FAIL pre-reset tx on B: got %b want %b", {DO1B, DO0B, DO1A, DO0A}, {d1, ~d1, 2'b00});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (out_vec() !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL reset mid-tx immediate: got %b want %b", out_vec(), RESET_VEC);
        end
        repeat (3) tick();
        checks++;
        if (out_vec() !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL reset mid-tx held: got %b want %b", out_vec(), RESET_VEC);
        end
        tx_busy = 1'b0;
        DO1_tx  = 1'b0;
        DO0_tx  = 1'b0;
        reset   = 1'b0;
        repeat (3) tick();
        run_tx("after_reset_tx_a", 1'b0, 1);
    endtask

    initial begin
        reset   = 1'b1;
        DI1A    = 1'b0;
        DI0A    = 1'b0;
        DI1B    = 1'b0;
        DI0B    = 1'b0;
        tx_busy = 1'b0;
        DO1_tx  = 1'b0;
        DO0_tx  = 1'b0;
        test_reset();
        test_glitch();
        test_word_a();
        test_simultaneous();
        test_collision_late();
        test_b_first();
        test_response_b();
        test_reset_mid_tx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mkio_bus_select.md
Name: mkio_bus_select

Overview:
Dual-redundant line front-end between the A/B transceiver pins and the Manchester receiver/transmitter.
- Synchronises and glitch-filters the four receive lines.
- Locks onto the first channel that becomes active and forwards only that channel to the receiver.
- Steers the transmitter output and the TX_INHIBIT/RX_STROB controls onto the channel the last command arrived on.

Parameters:
FILT_LEN, 3, consecutive equal clk32 samples required before a filtered line changes (2..7)
IDLE_CYC, 96, clk32 cycles of no activity on the locked channel before releasing the lock
HOLD_CYC, 8, clk32 cycles the receiver stays blocked after tx_busy falls

Ports:
clk32  in  1  32 MHz system clock
reset  in  1  reset
DI1A, DI0A  in  1 each  channel A receive pins (asynchronous)
DI1B, DI0B  in  1 each  channel B receive pins (asynchronous)
tx_busy  in  1  transmitter busy (clk16 derived from clk32, so synchronous)
DO1_tx, DO0_tx  in  1 each  transmitter line outputs
DI1, DI0  out  1 each  filtered, selected lines to the receiver
DO1A, DO0A, DO1B, DO0B  out  1 each  steered transmit lines
TX_INHIBIT_A, TX_INHIBIT_B  out  1 each  1 = transmitter driver inhibited
RX_STROB_A, RX_STROB_B  out  1 each  1 = receiver enabled
active_ch  out  2  00 none, 01 A, 10 B
collision  out  1  one-cycle pulse on activity on the non-selected channel

Behaviour:
- reset: asynchronous, active-high; clock: clk32.
- All outputs are registered. Reset values:
  - state IDLE, last_ch=A
  - DI1=DI0=0; all DO*=0
  - TX_INHIBIT_A/B=1; RX_STROB_A/B=1
  - active_ch=00; collision=0
- Input path, per line:
  - 2-flop synchroniser, then glitch filter.
  - The filter changes its output on the FILT_LEN-th consecutive sample of the new value.
  - 1 output register.
  - Pin-to-DI latency is FILT_LEN+3 cycles (6 at default).
  - Pulses shorter than FILT_LEN cycles never appear.
- Activity: act_X = f1X | f0X, computed on the filtered lines. f1X=f0X=1 together still counts as activity.
- FSM states: IDLE, RX_A, RX_B, TX, TX_HOLD.
- IDLE:
  - DI=0.
  - act_A only -> RX_A.
  - act_B only -> RX_B.
  - act_A and act_B in the same cycle -> RX_A (A priority) and pulse collision.
  - tx_busy=1 takes precedence over activity -> TX.
- RX_x:
  - DI1/DI0 = filtered lines of x; active_ch = x; last_ch <= x on entry.
  - idle_cnt clears on any act_x and increments otherwise.
  - idle_cnt == IDLE_CYC-1 -> IDLE; the counter saturates and cannot wrap.
  - Activity on the other channel is ignored. collision pulses once on its rising act and is not re-armed until IDLE.
  - tx_busy=1 -> TX; idle_cnt cleared.
- TX:
  - tx_ch = last_ch.
  - DO1/DO0 of tx_ch = DO1_tx/DO0_tx, delayed 1 cycle. Other channel DO = 0.
  - TX_INHIBIT_tx_ch=0 and RX_STROB_tx_ch=0; the other channel holds 1/1.
  - DI forced 0; active_ch=00.
  - tx_busy falling -> TX_HOLD.
- TX_HOLD:
  - DO=0, TX_INHIBIT_tx_ch=1, RX_STROB_tx_ch still 0.
  - hold_cnt runs to HOLD_CYC-1, then -> IDLE and RX_STROB restored.
  - tx_busy rising during hold -> TX; hold_cnt cleared.
- Receive activity during TX or TX_HOLD is ignored on both channels. No collision is signalled.
- Reset asserted mid-operation returns every register to its reset value immediately. A word in progress is truncated; DO lines drop to 0.

Decomposition:
- Package mkio_pkg holds:
  - state enum (IDLE, RX_A, RX_B, TX, TX_HOLD)
  - channel encoding CH_A=0, CH_B=1
  - active_ch codes
  - default constants FILT_LEN, IDLE_CYC, HOLD_CYC
- Sub-module mkio_glitch_filter: synchroniser plus counter-based stability filter on one line, parameterised by FILT_LEN. Instantiated 4 times.
- FSM, counters and steering stay in mkio_bus_select.

Test Plan:
- Reset: hold reset 5 cycles, release -> DI=0, all DO=0, TX_INHIBIT_A/B=1, RX_STROB_A/B=1, active_ch=00, collision=0.
- Glitch: 2-cycle high pulse on DI1A with FILT_LEN=3 -> DI1 stays 0, active_ch stays 00.
- Channel A word:
  - Stimulus: 1 µs bits on DI1A/DI0A.
  - DI1/DI0 reproduce the waveform delayed exactly 6 cycles.
  - active_ch=01 from first filtered edge.
  - After last edge, 96 cycles later active_ch=00.
- Simultaneous A and B start edge -> active_ch=01, collision high exactly 1 cycle, B waveform never on DI.
- Response on B:
  - Stimulus: word on B, then tx_busy=1 with DO_tx toggling.
  - DO1B/DO0B follow DO_tx +1 cycle; DO1A/DO0A=0.
  - TX_INHIBIT_B=0, RX_STROB_B=0; A side 1/1.
  - tx_busy falls -> TX_INHIBIT_B=1 next cycle, RX_STROB_B=1 after 8 cycles.
- Reset mid-TX: assert reset while DO1B toggling -> all outputs at reset values immediately. After release, tx_busy=1 drives channel A (last_ch=A).
